// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller for the 6-stage stall bus, with a sticky stall watchdog.
// Define STALL_PERF_EN to add per-source stall and flush-entry performance counters.
module pipe_stall_ctrl #(
  parameter int STALL_WD     = 6,
  parameter int FLUSH_CYCLES = 1,
  parameter int MAX_STALL    = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stallreq_id,
  input  logic                stallreq_ex,
  input  logic                stallreq_mem,
  input  logic                flush_req,
  input  logic [31:0]         flush_pc,
  output logic [STALL_WD-1:0] stall,
  output logic                flush,
  output logic [31:0]         new_pc,
  output logic                stall_timeout,
  output logic                state_dbg
`ifdef STALL_PERF_EN
  ,
  output logic [31:0]         perf_id_cnt,
  output logic [31:0]         perf_ex_cnt,
  output logic [31:0]         perf_mem_cnt,
  output logic [31:0]         perf_flush_cnt
`endif
);

  typedef enum logic {S_RUN, S_FLUSH} state_t;

  localparam logic [STALL_WD-1:0] STALL_MEM = STALL_WD'(6'b011111);
  localparam logic [STALL_WD-1:0] STALL_EX  = STALL_WD'(6'b001111);
  localparam logic [STALL_WD-1:0] STALL_ID  = STALL_WD'(6'b000111);
  localparam logic [3:0]          FC_LOAD   = 4'(FLUSH_CYCLES - 1);
  localparam logic [7:0]          WD_LIMIT  = 8'(MAX_STALL - 1);

  state_t              state;
  logic [3:0]          flush_left;
  logic [7:0]          wd_cnt;
  logic [STALL_WD-1:0] stall_req;

  always_comb begin
    stall_req = '0;
    if (stallreq_mem)     stall_req = STALL_MEM;
    else if (stallreq_ex) stall_req = STALL_EX;
    else if (stallreq_id) stall_req = STALL_ID;
  end

  // Stall applies in the request cycle; it is forced to NoStop while flushing or held in reset.
  assign stall     = (state == S_RUN && rst) ? stall_req : '0;
  assign state_dbg = (state == S_FLUSH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_RUN;
      flush         <= 1'b0;
      flush_left    <= '0;
      new_pc        <= '0;
      wd_cnt        <= '0;
      stall_timeout <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          if (flush_req) begin
            state      <= S_FLUSH;
            flush      <= 1'b1;
            new_pc     <= flush_pc;
            flush_left <= FC_LOAD;
          end
        end
        S_FLUSH: begin
          // A redirect arriving mid-flush restarts the sequence toward the newest target.
          if (flush_req) begin
            new_pc     <= flush_pc;
            flush_left <= FC_LOAD;
          end else if (flush_left == '0) begin
            state <= S_RUN;
            flush <= 1'b0;
          end else begin
            flush_left <= flush_left - 4'd1;
          end
        end
        default: begin
          state <= S_RUN;
          flush <= 1'b0;
        end
      endcase

      if (state == S_FLUSH || stall == '0) wd_cnt <= '0;
      else if (wd_cnt != 8'hff)             wd_cnt <= wd_cnt + 8'd1;

      // Entering FLUSH is the only recovery from a watchdog hit short of reset.
      if (flush_req)                                 stall_timeout <= 1'b0;
      else if (stall != '0 && wd_cnt == WD_LIMIT)    stall_timeout <= 1'b1;
    end
  end

`ifdef STALL_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_id_cnt    <= '0;
      perf_ex_cnt    <= '0;
      perf_mem_cnt   <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (state == S_RUN) begin
        if (stallreq_mem)     perf_mem_cnt <= perf_mem_cnt + 32'd1;
        else if (stallreq_ex) perf_ex_cnt  <= perf_ex_cnt + 32'd1;
        else if (stallreq_id) perf_id_cnt  <= perf_id_cnt + 32'd1;
      end
      if (flush_req) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Randomized + directed bench for pipe_stall_ctrl: two instances (FLUSH_CYCLES=1/MAX_STALL=64 and
// FLUSH_CYCLES=3/MAX_STALL=4) share stimulus; a reference model feeds per-instance expected queues.
module tb_pipe_stall_ctrl;
  localparam int FC_A = 1, MS_A = 64, FC_B = 3, MS_B = 4;
  localparam int EW = 40;  // {stall[5:0], flush, new_pc[31:0], stall_timeout}

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        stallreq_id = 1'b0, stallreq_ex = 1'b0, stallreq_mem = 1'b0, flush_req = 1'b0;
  logic [31:0] flush_pc = '0;

  logic [5:0]  stall_a, stall_b;
  logic        flush_a, flush_b, to_a, to_b, st_a, st_b;
  logic [31:0] new_pc_a, new_pc_b;
`ifdef STALL_PERF_EN
  logic [31:0] pid_a, pex_a, pmem_a, pfl_a, pid_b, pex_b, pmem_b, pfl_b;
`endif

  pipe_stall_ctrl #(.STALL_WD(6), .FLUSH_CYCLES(FC_A), .MAX_STALL(MS_A)) dut_a (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
    .stallreq_mem(stallreq_mem), .flush_req(flush_req), .flush_pc(flush_pc),
    .stall(stall_a), .flush(flush_a), .new_pc(new_pc_a), .stall_timeout(to_a), .state_dbg(st_a)
`ifdef STALL_PERF_EN
    , .perf_id_cnt(pid_a), .perf_ex_cnt(pex_a), .perf_mem_cnt(pmem_a), .perf_flush_cnt(pfl_a)
`endif
  );

  pipe_stall_ctrl #(.STALL_WD(6), .FLUSH_CYCLES(FC_B), .MAX_STALL(MS_B)) dut_b (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
    .stallreq_mem(stallreq_mem), .flush_req(flush_req), .flush_pc(flush_pc),
    .stall(stall_b), .flush(flush_b), .new_pc(new_pc_b), .stall_timeout(to_b), .state_dbg(st_b)
`ifdef STALL_PERF_EN
    , .perf_id_cnt(pid_b), .perf_ex_cnt(pex_b), .perf_mem_cnt(pmem_b), .perf_flush_cnt(pfl_b)
`endif
  );

  // Scoreboard state
  int checks = 0;
  int failures = 0;
  logic [EW-1:0]  exp_q_a[$], exp_q_b[$];
  logic [127:0]   perf_q_a[$], perf_q_b[$];

  // Reference model: one slot per instance
  int          fc[2], ms[2];
  bit          m_in_flush[2];
  int          m_left[2];     // flush cycles still to be shown, including the current one
  logic [31:0] m_pc[2];
  int          m_run[2];      // length of the current run of stalled cycles
  bit          m_to[2];
  int unsigned m_pid[2], m_pex[2], m_pmem[2], m_pfl[2];

  // Number of stages held = index of the winning requester's stage + 1 (PC..MEM is 5).
  function automatic logic [5:0] held_mask(logic id, logic ex, logic mem);
    int n;
    n = mem ? 5 : (ex ? 4 : (id ? 3 : 0));
    return 6'((1 << n) - 1);
  endfunction

  function void model_reset(int k);
    m_in_flush[k] = 0; m_left[k] = 0; m_pc[k] = '0; m_run[k] = 0; m_to[k] = 0;
    m_pid[k] = 0; m_pex[k] = 0; m_pmem[k] = 0; m_pfl[k] = 0;
  endfunction

  function void model_cycle(int k, logic r, logic id, logic ex, logic mem, logic fr,
                            logic [31:0] pc, output logic [EW-1:0] e, output logic [127:0] pe);
    logic [5:0] s;
    if (!r) begin
      model_reset(k);
      e  = '0;
      pe = '0;
      return;
    end
    s  = m_in_flush[k] ? 6'd0 : held_mask(id, ex, mem);
    e  = {s, m_in_flush[k], m_pc[k], m_to[k]};
    pe = {m_pid[k], m_pex[k], m_pmem[k], m_pfl[k]};
    if (!m_in_flush[k]) begin
      if (mem)     m_pmem[k]++;
      else if (ex) m_pex[k]++;
      else if (id) m_pid[k]++;
    end
    if (fr) begin
      m_in_flush[k] = 1; m_left[k] = fc[k]; m_pc[k] = pc; m_to[k] = 0; m_run[k] = 0;
      m_pfl[k]++;
    end else if (m_in_flush[k]) begin
      m_left[k]--;
      if (m_left[k] == 0) m_in_flush[k] = 0;
      m_run[k] = 0;
    end else if (s != 0) begin
      m_run[k]++;
      if (m_run[k] >= ms[k]) m_to[k] = 1;
    end else begin
      m_run[k] = 0;
    end
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Driver: apply one cycle of inputs just after the edge and queue what that cycle should show.
  task automatic drive(logic r, logic id, logic ex, logic mem, logic fr, logic [31:0] pc);
    logic [EW-1:0] e;
    logic [127:0]  pe;
    @(posedge clk);
    #1;
    rst = r; stallreq_id = id; stallreq_ex = ex; stallreq_mem = mem;
    flush_req = fr; flush_pc = pc;
    model_cycle(0, r, id, ex, mem, fr, pc, e, pe);
    exp_q_a.push_back(e);
    perf_q_a.push_back(pe);
    model_cycle(1, r, id, ex, mem, fr, pc, e, pe);
    exp_q_b.push_back(e);
    perf_q_b.push_back(pe);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 32'h0);
  endtask

  // Monitor: sample mid-cycle on the falling edge
  initial begin
    logic [EW-1:0] e;
    logic [127:0]  pe;
    forever begin
      @(negedge clk);
      if (exp_q_a.size() > 0) begin
        e  = exp_q_a.pop_front();
        pe = perf_q_a.pop_front();
        chk("a_stall", 32'(stall_a), 32'(e[39:34]));
        chk("a_flush", 32'(flush_a), 32'(e[33]));
        chk("a_state", 32'(st_a), 32'(e[33]));
        chk("a_new_pc", new_pc_a, e[32:1]);
        chk("a_timeout", 32'(to_a), 32'(e[0]));
`ifdef STALL_PERF_EN
        chk("a_perf_id", pid_a, pe[127:96]);
        chk("a_perf_ex", pex_a, pe[95:64]);
        chk("a_perf_mem", pmem_a, pe[63:32]);
        chk("a_perf_flush", pfl_a, pe[31:0]);
`endif
      end
      if (exp_q_b.size() > 0) begin
        e  = exp_q_b.pop_front();
        pe = perf_q_b.pop_front();
        chk("b_stall", 32'(stall_b), 32'(e[39:34]));
        chk("b_flush", 32'(flush_b), 32'(e[33]));
        chk("b_state", 32'(st_b), 32'(e[33]));
        chk("b_new_pc", new_pc_b, e[32:1]);
        chk("b_timeout", 32'(to_b), 32'(e[0]));
`ifdef STALL_PERF_EN
        chk("b_perf_id", pid_b, pe[127:96]);
        chk("b_perf_ex", pex_b, pe[95:64]);
        chk("b_perf_mem", pmem_b, pe[63:32]);
        chk("b_perf_flush", pfl_b, pe[31:0]);
`endif
      end
    end
  end

  // Stimulus
  initial begin
    int pm;
    fc[0] = FC_A; ms[0] = MS_A; fc[1] = FC_B; ms[1] = MS_B;
    model_reset(0);
    model_reset(1);

    // Held in reset with requests present: everything must read 0
    drive(0, 0, 0, 0, 0, 32'h0);
    drive(0, 1, 1, 1, 0, 32'h0);
    drive(1, 0, 0, 0, 0, 32'h0);

    // Priority
    drive(1, 1, 0, 0, 0, 32'h0);
    idle(1);
    drive(1, 1, 1, 1, 0, 32'h0);
    drive(1, 1, 1, 0, 0, 32'h0);
    drive(1, 1, 0, 0, 0, 32'h0);
    idle(1);

    // Flush while EX is stalling
    drive(1, 0, 1, 0, 1, 32'hBFC00380);
    repeat (4) drive(1, 0, 1, 0, 0, 32'h0);
    idle(1);

    // Back-to-back flush, latest redirect wins
    drive(1, 0, 0, 0, 1, 32'h00000100);
    drive(1, 1, 0, 1, 1, 32'h00000200);
    idle(5);

    // Watchdog: 3 stalled cycles, then 4, then clear by flush
    repeat (3) drive(1, 0, 0, 1, 0, 32'h0);
    idle(1);
    repeat (4) drive(1, 0, 0, 1, 0, 32'h0);
    idle(2);
    drive(1, 0, 0, 0, 1, 32'h00000040);
    idle(4);

    // Reset in the middle of a stall run with the watchdog set
    repeat (5) drive(1, 0, 0, 1, 0, 32'h0);
    drive(0, 0, 0, 1, 0, 32'h0);
    drive(1, 1, 0, 0, 0, 32'h0);

    // Reset during the second flush cycle, between edges
    drive(1, 0, 0, 0, 1, 32'hDEADBEEC);
    drive(1, 0, 0, 0, 0, 32'h0);
    drive(0, 1, 0, 0, 0, 32'h0);
    drive(1, 1, 0, 0, 0, 32'h0);
    idle(1);

    // Perf-style sequence: 5 id-only, 3 ex+id, 2 flushes
    drive(0, 0, 0, 0, 0, 32'h0);
    repeat (5) drive(1, 1, 0, 0, 0, 32'h0);
    repeat (3) drive(1, 1, 1, 0, 0, 32'h0);
    drive(1, 0, 0, 0, 1, 32'h00001000);
    idle(4);
    drive(1, 0, 0, 0, 1, 32'h00002000);
    idle(4);

    // Randomized phases alternating light and heavy MEM pressure
    for (int i = 0; i < 600; i++) begin
      pm = ((i / 100) % 2 == 1) ? 85 : 20;
      drive(($urandom_range(0, 79) != 0),
            ($urandom_range(0, 99) < 40),
            ($urandom_range(0, 99) < 25),
            ($urandom_range(0, 99) < pm),
            ($urandom_range(0, 13) == 0),
            $urandom);
    end
    idle(2);

    @(negedge clk);
    #1;
    chk("queue_drain_a", 32'(exp_q_a.size()), 32'd0);
    chk("queue_drain_b", 32'(exp_q_b.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
